// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package loader_pkg;

    typedef enum logic [1:0] {
        S_LEN  = 2'd0,
        S_DATA = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_WIDTH      = 32;

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian 32-bit word from a byte stream, one lane per accepted byte.
module byte_packer
    import loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic [HDR_WIDTH-1:0] word,
    output logic                 word_ready
);

    logic [1:0]           byte_cnt_q;
    logic [HDR_WIDTH-1:0] word_q;

    // Lane counter and partial-word store; the counter wraps to 0 after the 4th byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= 2'd0;
            word_q     <= '0;
        end else if (in_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            word_q     <= word;
        end
    end

    // Merge the incoming byte into its lane so the full word is visible on the 4th byte.
    always_comb begin
        word                      = word_q;
        word[8*byte_cnt_q +: 8]   = in_data;
        word_ready                = in_valid && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length header then N words, written sequentially; holds the CPU in reset until done.
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    // Must hold the value MAX_WORDS without wrapping.
    localparam int unsigned CntW = $clog2(MAX_WORDS + 1);

    state_t               state_q, state_d;
    logic                 accept;
    logic                 word_ready;
    logic [HDR_WIDTH-1:0] packed_word;
    logic [HDR_WIDTH-1:0] len_q;
    logic [CntW-1:0]      word_cnt_q;
    logic                 hdr_bad;
    logic                 last_word;
    logic                 mem_we_q;
    logic [31:0]          mem_addr_q;
    logic [31:0]          mem_wdata_q;

    assign accept = rx_valid && rx_ready;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (accept),
        .in_data    (rx_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    assign hdr_bad   = (packed_word == '0) || (packed_word > HDR_WIDTH'(MAX_WORDS));
    assign last_word = (HDR_WIDTH'(word_cnt_q) == (len_q - HDR_WIDTH'(1)));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; header check and last-word exit happen on the completing byte.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LEN:  if (word_ready) state_d = hdr_bad ? S_ERR : S_DATA;
            S_DATA: if (word_ready && last_word) state_d = S_DONE;
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_LEN;
        endcase
    end

    // FSM outputs, derived from registered state only (reset gates ready).
    always_comb begin
        rx_ready  = !reset && ((state_q == S_LEN) || (state_q == S_DATA));
        done      = (state_q == S_DONE);
        error     = (state_q == S_ERR);
        cpu_reset = (state_q != S_DONE);
    end

    // Header capture, word counter and registered memory write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q       <= '0;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            if ((state_q == S_LEN) && word_ready) begin
                len_q      <= packed_word;
                word_cnt_q <= '0;
            end
            if ((state_q == S_DATA) && word_ready) begin
                mem_we_q    <= 1'b1;
                mem_wdata_q <= packed_word;
                mem_addr_q  <= BASE_ADDR + (32'(word_cnt_q) << 2);
                word_cnt_q  <= word_cnt_q + CntW'(1);
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes, a monitor pops them.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic prev_we = 1'b0;

    imem_loader #(
        .MAX_WORDS (64),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we === 1'b1) begin
            if (prev_we) begin
                checks++;
                errors++;
                $display("FAIL we_double: strobe held for 2 cycles");
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_we: addr 0x%08h data 0x%08h", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("we_addr", mem_addr, e.addr);
                check("we_data", mem_wdata, e.data);
                check("we_done", 32'(done), 32'(e.last));
                check("we_cpu_reset", 32'(cpu_reset), 32'(!e.last));
            end
        end
        prev_we = (mem_we === 1'b1);
    end

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] data, input logic last);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Present one byte, wait (bounded) for it to be accepted, then check strobe timing.
    task automatic send_byte(input logic [7:0] b, input int gap, input logic expect_we);
        int n;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte 0x%02h not accepted", b);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("we_latency", 32'(mem_we), 32'(expect_we));
        repeat (gap) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap, input logic is_data);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap, is_data && (i == 3));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;
    endtask

    task automatic load_two(input int gap);
        send_word(32'd2, gap, 1'b0);
        push_exp(32'h0, 32'h0050_0513, 1'b0);
        send_word(32'h0050_0513, gap, 1'b1);
        push_exp(32'h4, 32'h0000_006F, 1'b1);
        send_word(32'h0000_006F, gap, 1'b1);
        repeat (2) @(negedge clk);
        check("two_done", 32'(done), 32'd1);
        check("two_cpu_reset", 32'(cpu_reset), 32'd0);
        check("two_rx_ready", 32'(rx_ready), 32'd0);
        check("two_addr_hold", mem_addr, 32'h4);
        check("two_data_hold", mem_wdata, 32'h0000_006F);
    endtask

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rx_ready_init", 32'(rx_ready), 32'd0);
        check("rst_cpu_reset_init", 32'(cpu_reset), 32'd1);
        check("rst_done_init", 32'(done), 32'd0);
        check("rst_error_init", 32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_rx_ready", 32'(rx_ready), 32'd1);

        // Normal back-to-back load.
        load_two(0);

        // Backpressure after done.
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (20) @(negedge clk);
        check("bp_done", 32'(done), 32'd1);
        check("bp_cpu_reset", 32'(cpu_reset), 32'd0);
        check("bp_rx_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;

        // Gapped stream.
        do_reset();
        load_two(3);

        // Zero-length header.
        do_reset();
        send_word(32'd0, 0, 1'b0);
        check("zero_error", 32'(error), 32'd1);
        check("zero_cpu_reset", 32'(cpu_reset), 32'd1);
        check("zero_rx_ready", 32'(rx_ready), 32'd0);
        check("zero_done", 32'(done), 32'd0);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (10) @(negedge clk);
        rx_valid = 1'b0;
        check("zero_error_sticky", 32'(error), 32'd1);
        do_reset();

        // Oversize header.
        send_word(32'd65, 0, 1'b0);
        check("over_error", 32'(error), 32'd1);
        check("over_cpu_reset", 32'(cpu_reset), 32'd1);

        // Maximum legal length.
        do_reset();
        send_word(32'd64, 0, 1'b0);
        check("max_hdr_error", 32'(error), 32'd0);
        for (int i = 0; i < 64; i++) begin
            push_exp(32'(i) * 32'd4, 32'hA5A5_0000 + 32'(i), i == 63);
            send_word(32'hA5A5_0000 + 32'(i), 0, 1'b1);
        end
        repeat (2) @(negedge clk);
        check("max_last_addr", mem_addr, 32'h0000_00FC);
        check("max_done", 32'(done), 32'd1);

        // Reset mid-word: partial data must never be written.
        do_reset();
        send_word(32'd1, 0, 1'b0);
        send_byte(8'h13, 0, 1'b0);
        send_byte(8'h05, 0, 1'b0);
        do_reset();
        send_word(32'd1, 0, 1'b0);
        push_exp(32'h0, 32'hDEAD_BEEF, 1'b1);
        send_word(32'hDEAD_BEEF, 0, 1'b1);
        repeat (3) @(negedge clk);
        check("mid_done", 32'(done), 32'd1);

        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
